// File: rtl/add_pkg.sv
// Shared types and helpers for the sequential multi-byte adder.
// One 8-bit slice is reused across all operand bytes.
package add_pkg;

  localparam int BYTE_W    = 8;
  localparam int MAX_BYTES = 16;
  localparam int MAX_W     = BYTE_W * MAX_BYTES;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Byte i of a vector zero-extended to MAX_W bits
  function automatic logic [BYTE_W-1:0] byte_at(
    input logic [MAX_W-1:0] v,
    input logic [3:0]       i
  );
    return v[{i, 3'b000} +: BYTE_W];
  endfunction

endpackage

// File: rtl/add8_slice.sv
// 8-bit combinational ripple-carry adder slice.
// Carry ripples from bit 0 upward through full-adder cells.
module add8_slice
  import add_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              cin,
  output logic [BYTE_W-1:0] sum,
  output logic              cout
);

  logic [BYTE_W:0] w_c;

  assign w_c[0] = cin;

  for (genvar i = 0; i < BYTE_W; i++) begin : g_fa
    assign sum[i]     = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i+1]   = (a[i] & b[i])
                      | (w_c[i] & (a[i] ^ b[i]));
  end

  assign cout = w_c[BYTE_W];

endmodule

// File: rtl/multiword_add_seq.sv
// Wide add/subtract built from one 8-bit slice, one byte per cycle.
// Operands arrive and results leave over valid/ready handshakes.
module multiword_add_seq
  import add_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [BYTE_W*NBYTES-1:0] a,
  input  logic [BYTE_W*NBYTES-1:0] b,
  input  logic                     cin,
  input  logic                     sub,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BYTE_W*NBYTES-1:0] sum,
  output logic                     cout,
  output logic                     overflow
);

  localparam int W  = BYTE_W * NBYTES;
  localparam int IW = $clog2(NBYTES);
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  state_e          r_state;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_sum;
  logic            r_carry;
  logic            r_cout;
  logic            r_ovf;
  logic [IW-1:0]   r_idx;

  logic [BYTE_W-1:0] w_a_byte;
  logic [BYTE_W-1:0] w_b_byte;
  logic [BYTE_W-1:0] w_s;
  logic              w_co;
  logic              w_ovf;

  assign w_a_byte = byte_at(MAX_W'(r_a), 4'(r_idx));
  assign w_b_byte = byte_at(MAX_W'(r_b), 4'(r_idx));

  add8_slice u_slice (
    .a    (w_a_byte),
    .b    (w_b_byte),
    .cin  (r_carry),
    .sum  (w_s),
    .cout (w_co)
  );

  // r_b already holds ~B for subtract, so one rule covers both ops
  assign w_ovf = (r_a[W-1] == r_b[W-1])
              && (w_s[BYTE_W-1] != r_a[W-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_idx   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub | cin;
            r_idx   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          for (int k = 0; k < NBYTES; k++) begin
            if (r_idx == IW'(k)) begin
              r_sum[k*BYTE_W +: BYTE_W] <= w_s;
            end
          end
          r_carry <= w_co;
          if (r_idx == LAST) begin
            r_idx   <= '0;
            r_cout  <= w_co;
            r_ovf   <= w_ovf;
            r_state <= DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_multiword_add_seq.sv
// Randomised bench for multiword_add_seq against an arithmetic model.
// Covers wrap, overflow, subtract, backpressure, reset and back-to-back.
module tb_multiword_add_seq;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0] o_sum;
  logic         o_cout;
  logic         o_ovf;
  int           o_lat;

  always #5 clk = ~clk;

  multiword_add_seq #(.NBYTES(NB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow)
  );

  // Returns {cout, overflow, sum} from plain integer arithmetic
  function automatic logic [W+1:0] ref_op(
    input logic [W-1:0] ra,
    input logic [W-1:0] rb,
    input bit           rc,
    input bit           rs
  );
    longint ua, ub, sa, sb, u, s;
    bit co, ov;
    ua = longint'({32'h0, ra});
    ub = longint'({32'h0, rb});
    sa = longint'($signed(ra));
    sb = longint'($signed(rb));
    if (!rs) begin
      u  = ua + ub + longint'(rc);
      s  = sa + sb + longint'(rc);
      co = (u >= 64'sh1_0000_0000);
    end else begin
      u  = ua - ub;
      s  = sa - sb;
      co = (ua >= ub);
    end
    ov = (s > 64'sh7FFF_FFFF) || (s < -64'sh8000_0000);
    return {co, ov, u[W-1:0]};
  endfunction

  // Called #1 after an edge while idle; accepts on the next edge
  task automatic run_op(
    input logic [W-1:0] ta,
    input logic [W-1:0] tb,
    input bit           tc,
    input bit           ts,
    input bit           hs,
    input bit           pre
  );
    a = ta; b = tb; cin = tc; sub = ts;
    in_valid = 1'b1;
    if (pre) out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom;
    o_lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        o_lat = n;
        break;
      end
    end
    o_sum = sum; o_cout = cout; o_ovf = overflow;
    if (hs && o_lat != 0) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
    end
    if (hs) out_ready = 1'b0;
  endtask

  task automatic test_reset;
    logic [W+3:0] got, exp;
    in_valid = 1'b1; a = 32'h1234_5678; b = 32'h1;
    #1;
    got = {sum, cout, overflow, out_valid, in_ready};
    exp = {32'h0, 4'b0001};
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL reset_state: got %h want %h", got, exp);
    end
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    got = {sum, cout, overflow, out_valid, in_ready};
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL reset_no_capture: got %h want %h", got, exp);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: got rdy=%b vld=%b want 1 0",
               in_ready, out_valid);
    end
  endtask

  task automatic check_op(
    input string        nm,
    input logic [W-1:0] ta,
    input logic [W-1:0] tb,
    input bit           tc,
    input bit           ts,
    input bit           pre
  );
    logic [W+1:0] exp;
    exp = ref_op(ta, tb, tc, ts);
    run_op(ta, tb, tc, ts, 1'b1, pre);
    n_vec++;
    if ({o_cout, o_ovf, o_sum} !== exp || o_lat != NB) begin
      n_err++;
      $display("FAIL %s: got sum=%h cout=%b ovf=%b lat=%0d want sum=%h cout=%b ovf=%b lat=%0d",
               nm, o_sum, o_cout, o_ovf, o_lat,
               exp[W-1:0], exp[W+1], exp[W], NB);
    end
  endtask

  task automatic test_wrap;
    check_op("wrap", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_overflow;
    check_op("ovf_pos", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0);
    check_op("ovf_neg", 32'h8000_0000, 32'hFFFF_FFFF,
             1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_subtract;
    check_op("sub_neg", 32'd5, 32'd7, 1'b1, 1'b1, 1'b0);
    check_op("sub_pos", 32'd7, 32'd5, 1'b0, 1'b1, 1'b0);
    check_op("sub_minovf", 32'h8000_0000, 32'h1, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_backpressure;
    logic [W-1:0] ta, tb;
    logic [W+1:0] exp;
    ta = $urandom; tb = $urandom;
    exp = ref_op(ta, tb, 1'b1, 1'b0);
    run_op(ta, tb, 1'b1, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if ({o_cout, o_ovf, o_sum} !== exp || o_lat != NB) begin
      n_err++;
      $display("FAIL bp_result: got %h lat=%0d want %h lat=%0d",
               {o_cout, o_ovf, o_sum}, o_lat, exp, NB);
    end
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = $urandom; b = $urandom;
      sub = 1'($urandom); cin = 1'($urandom);
      @(posedge clk); #1;
      n_vec++;
      if ({cout, overflow, sum} !== exp || in_ready !== 1'b0
          || out_valid !== 1'b1) begin
        n_err++;
        $display("FAIL bp_hold%0d: got %h rdy=%b vld=%b want %h 0 1",
                 i, {cout, overflow, sum}, in_ready, out_valid, exp);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL bp_release: got rdy=%b vld=%b want 1 0",
               in_ready, out_valid);
    end
    check_op("bp_next", $urandom, $urandom, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_midrun;
    logic [W+3:0] got;
    a = 32'h0102_0304; b = 32'h1010_1010; cin = 1'b0; sub = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    got = {sum, cout, overflow, out_valid, in_ready};
    n_vec++;
    if (got !== {32'h0, 4'b0001}) begin
      n_err++;
      $display("FAIL reset_async: got %h want %h",
               got, {32'h0, 4'b0001});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_op("post_reset", 32'h0000_0100, 32'h0000_00FF,
             1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back;
    check_op("b2b_chain", 32'h00FF_FFFF, 32'h0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL b2b_ready%0d: got %b want 1", i, in_ready);
      end
      check_op("b2b_next", $urandom, $urandom,
               1'($urandom), 1'($urandom), 1'b0);
    end
  endtask

  task automatic test_random;
    logic [W-1:0] ta, tb;
    for (int i = 0; i < 20; i++) begin
      ta = $urandom; tb = $urandom;
      if (i % 5 == 0) ta = 32'h8000_0000;
      if (i % 7 == 0) tb = 32'hFFFF_FFFF;
      check_op("random", ta, tb, 1'($urandom), 1'($urandom),
               1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_overflow();
    test_subtract();
    test_backpressure();
    test_reset_midrun();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
